// File: rtl/riscv_defines_pkg.sv
// riscv_defines: shared types and constants for the fetch/BTB front end
package riscv_defines;
   localparam int TABLE_ENTRIES = 64;
   localparam int INDEX_WIDTH   = $clog2(TABLE_ENTRIES);
   localparam int TAG_WIDTH     = 32 - INDEX_WIDTH - 2;

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic [31:0]          target;
   } btb_entry_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {BOOT, RUN, PEND} fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        pred_taken;
      logic [31:0] pred_target;
   } if_id_t;
endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// next_pc_mux: priority select of the next fetch PC plus a kill flag for the IF/ID capture
module next_pc_mux (
   input  logic        redirect_e,
   input  logic [31:0] redirect_target_e,
   input  logic        redirect_d,
   input  logic [31:0] redirect_target_d,
   input  logic        pend_valid,
   input  logic [31:0] pend_target,
   input  logic        btb_hit,
   input  logic [31:0] pred_target,
   input  logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        kill
);
   // EX correction beats ID correction beats a latched ID target beats prediction beats sequential
   always_comb begin
      next_pc = redirect_e ? redirect_target_e :
                redirect_d ? redirect_target_d :
                pend_valid ? pend_target :
                btb_hit    ? pred_target : pc_plus4;
      kill    = redirect_e | redirect_d;
   end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC register, boot/pending-redirect FSM and IF/ID pipeline register
module fetch_pc_unit
   import riscv_defines::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        btb_hit,
   input  logic [31:0] pred_target,
   input  logic        redirect_d,
   input  logic [31:0] redirect_target_d,
   input  logic        redirect_e,
   input  logic [31:0] redirect_target_e,
   output logic [31:0] pc_f,
   output logic        valid_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        pred_taken_d,
   output logic [31:0] pred_target_d
);
   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d_nx, pend_q, pend_d, mux_pc;
   if_id_t       if_id_q, if_id_d;
   logic         kill;

   next_pc_mux u_mux (
      .redirect_e        (redirect_e),
      .redirect_target_e (redirect_target_e),
      .redirect_d        (redirect_d),
      .redirect_target_d (redirect_target_d),
      .pend_valid        (state_q == PEND),
      .pend_target       (pend_q),
      .btb_hit           (btb_hit),
      .pred_target       (pred_target),
      .pc_plus4          (pc_q + 32'd4),
      .next_pc           (mux_pc),
      .kill              (kill)
   );

   // Next PC / state: BOOT holds one cycle, a stalled ID redirect is parked until the stall clears
   always_comb begin
      state_d = state_q;
      pc_d_nx = pc_q;
      pend_d  = pend_q;
      if (state_q == BOOT) begin
         state_d = RUN;
         pc_d_nx = redirect_e ? redirect_target_e : pc_q;
      end else if (redirect_e) begin
         state_d = RUN;
         pc_d_nx = redirect_target_e;
      end else if (stall_f) begin
         if (redirect_d) begin
            state_d = PEND;
            pend_d  = redirect_target_d;
         end
      end else begin
         state_d = RUN;
         pc_d_nx = mux_pc;
      end
   end

   // IF/ID capture: bubble on any redirect, flush or non-RUN state; an EX redirect kills even a held entry
   always_comb begin
      if_id_d = if_id_q;
      if (!stall_d)
         if_id_d = '{valid: !(kill | flush_d | (state_q != RUN)), pc: pc_q, pc_plus4: pc_q + 32'd4,
                     pred_taken: btb_hit, pred_target: pred_target};
      else if (redirect_e)
         if_id_d.valid = 1'b0;
   end

   // State, PC, pending target and IF/ID registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         if_id_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d_nx;
         pend_q  <= pend_d;
         if_id_q <= if_id_d;
      end
   end

   assign pc_f          = pc_q;
   assign valid_d       = if_id_q.valid;
   assign pc_d          = if_id_q.pc;
   assign pc_plus4_d    = if_id_q.pc_plus4;
   assign pred_taken_d  = if_id_q.pred_taken;
   assign pred_target_d = if_id_q.pred_target;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed test-plan scenarios plus random stimulus against a behavioural model
module tb_fetch_pc_unit;
   localparam logic [31:0] RPC = 32'h100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_f = 0, stall_d = 0, flush_d = 0, btb_hit = 0, redirect_d = 0, redirect_e = 0;
   logic [31:0] pred_target = 0, redirect_target_d = 0, redirect_target_e = 0;
   logic [31:0] pc_f, pc_d, pc_plus4_d, pred_target_d;
   logic        valid_d, pred_taken_d;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit          valid;
      logic [31:0] pc;
      logic [31:0] p4;
      bit          pt;
      logic [31:0] tgt;
   } id_t;

   logic [31:0] m_pc;
   bit          m_boot;
   logic [31:0] m_pend[$];
   id_t         m_id;

   always #5 clk = ~clk;

   fetch_pc_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .btb_hit(btb_hit), .pred_target(pred_target),
      .redirect_d(redirect_d), .redirect_target_d(redirect_target_d),
      .redirect_e(redirect_e), .redirect_target_e(redirect_target_e),
      .pc_f(pc_f), .valid_d(valid_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RPC;
      m_boot = 1;
      m_pend.delete();
      m_id   = '{0, 0, 0, 0, 0};
   endtask

   task automatic check_model();
      check("pc_f", pc_f, m_pc);
      check("valid_d", {31'b0, valid_d}, {31'b0, m_id.valid});
      if (m_id.valid) begin
         check("pc_d", pc_d, m_id.pc);
         check("pc_plus4_d", pc_plus4_d, m_id.p4);
         check("pred_taken_d", {31'b0, pred_taken_d}, {31'b0, m_id.pt});
         check("pred_target_d", pred_target_d, m_id.tgt);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_pc_f"}, pc_f, RPC);
      check({tag, "_valid"}, {31'b0, valid_d}, 32'h0);
      check({tag, "_pc_d"}, pc_d, 32'h0);
      check({tag, "_p4"}, pc_plus4_d, 32'h0);
      check({tag, "_pt"}, {31'b0, pred_taken_d}, 32'h0);
      check({tag, "_ptgt"}, pred_target_d, 32'h0);
   endtask

   // Advance the model by one clock from the rules, then clock the DUT and compare
   task automatic step();
      logic [31:0] nxt;
      id_t         nid;
      bit          in_pend;
      in_pend = (m_pend.size() != 0);
      nxt = m_pc;
      nid = m_id;
      if (!stall_d)
         nid = '{!(flush_d || redirect_d || redirect_e || m_boot || in_pend), m_pc, m_pc + 32'd4, btb_hit, pred_target};
      else if (redirect_e)
         nid.valid = 0;
      if (m_boot) begin
         if (redirect_e) nxt = redirect_target_e;
         m_boot = 0;
      end else if (redirect_e) begin
         nxt = redirect_target_e;
         m_pend.delete();
      end else if (stall_f) begin
         if (redirect_d) begin
            m_pend.delete();
            m_pend.push_back(redirect_target_d);
         end
      end else begin
         nxt = redirect_d ? redirect_target_d : in_pend ? m_pend[0] : btb_hit ? pred_target : m_pc + 32'd4;
         m_pend.delete();
      end
      m_pc = nxt;
      m_id = nid;
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      {stall_f, stall_d, flush_d, btb_hit, redirect_d, redirect_e} = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset = 0;
      // sequential fetch from RESET_PC with the boot bubble
      step();
      check("boot_pc", pc_f, 32'h100);
      check("boot_bubble", {31'b0, valid_d}, 32'h0);
      step();
      check("seq_pc1", pc_f, 32'h104);
      check("seq_pc_d", pc_d, 32'h100);
      step();
      check("seq_pc2", pc_f, 32'h108);
      // predicted taken
      btb_hit = 1; pred_target = 32'h200;
      step();
      check("pred_pc", pc_f, 32'h200);
      check("pred_pc_d", pc_d, 32'h108);
      check("pred_taken", {31'b0, pred_taken_d}, 32'h1);
      check("pred_tgt_d", pred_target_d, 32'h200);
      // ID redirect parked under stall
      idle();
      stall_f = 1; redirect_d = 1; redirect_target_d = 32'h300;
      step();
      redirect_d = 0;
      repeat (2) step();
      check("pend_hold", pc_f, 32'h200);
      check("pend_bubble", {31'b0, valid_d}, 32'h0);
      stall_f = 0;
      step();
      check("pend_release", pc_f, 32'h300);
      // simultaneous redirects in PEND with stall_d
      stall_f = 1; redirect_d = 1; redirect_target_d = 32'h600;
      step();
      stall_d = 1; redirect_e = 1; redirect_target_e = 32'h400; redirect_target_d = 32'h500;
      step();
      check("sim_pc", pc_f, 32'h400);
      check("sim_kill", {31'b0, valid_d}, 32'h0);
      idle();
      repeat (3) step();
      check("sim_no500", pc_f, 32'h40c);
      // wrap-around
      redirect_e = 1; redirect_target_e = 32'hFFFF_FFFC;
      step();
      idle();
      step();
      check("wrap_pc", pc_f, 32'h0);
      check("wrap_p4", pc_plus4_d, 32'h0);
      check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
      // asynchronous reset while PEND
      stall_f = 1; redirect_d = 1; redirect_target_d = 32'h700;
      step();
      #2 reset = 1;
      #1 check_reset_vals("arst");
      @(negedge clk);
      reset = 0;
      idle();
      model_reset();
      step();
      check("arst_boot", pc_f, RPC);
      step();
      check("arst_seq", pc_f, RPC + 32'd4);
      // random stimulus
      for (int i = 0; i < 400; i++) begin
         stall_f           = ($urandom % 4) == 0;
         stall_d           = ($urandom % 5) == 0;
         flush_d           = ($urandom % 8) == 0;
         btb_hit           = ($urandom % 3) == 0;
         pred_target       = $urandom;
         redirect_d        = ($urandom % 6) == 0;
         redirect_target_d = $urandom;
         redirect_e        = ($urandom % 10) == 0;
         redirect_target_e = $urandom;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
